bridge_host_regs: RTL and testbench
===================================

# bridge_host_regs

Host-facing register front end for the CW305-to-X-HEEP loader path. Decodes the CW305 USB register interface (byte-wide, address plus byte count), assembles 32-bit instruction and section-address words, and issues single-cycle `instr_valid` / `addr_valid` commands to the downstream OBI bridge, holding them pending while the bridge reports `busy`. It also captures OBI read responses returned by the bridge so the host can read them back, and exposes a status register.

## Interface
- `pADDR_WIDTH`, 8, width of `reg_address`
- `pBYTECNT_SIZE`, 7, width of `reg_bytecnt`
- `clk`  in  1  system clock; all logic is on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `reg_address`  in  pADDR_WIDTH  host register address
- `reg_bytecnt`  in  pBYTECNT_SIZE  byte index within the register
- `reg_datai`  in  8  host write byte
- `reg_datao`  out  8  host read byte
- `reg_read`  in  1  host read strobe
- `reg_write`  in  1  host write strobe, one byte per cycle
- `busy`  in  1  bridge cannot accept a command
- `OBI_rvalid`  in  1  read response valid, one cycle
- `OBI_rdata`  in  32  read response data
- `instr_valid`  out  1  one-cycle instruction command
- `addr_valid`  out  1  one-cycle new-section command
- `instruction`  out  32  committed instruction word
- `new_section_address`  out  32  committed section address

## Operation
- Register map (`reg_address`), multi-byte registers little-endian, with `reg_bytecnt` 0..3:
  - 0x00 STATUS (RO): bit0 `busy`, bit1 `instr_pending`, bit2 `addr_pending`, bit3 `rdata_valid`, bit4 `cmd_overflow`, bit5 `rdata_lost`.
  - 0x01 INSTR (WO), 0x02 ADDR (WO), 0x03 RDATA (RO), 0x04 CTRL (WO): bit0 = 1 clears `cmd_overflow`; bit1 = 1 clears `rdata_lost`.
- A write of byte n goes into that register's staging word. A write of byte 3 is a commit:
  - If the matching pending flag is 0, staging is copied to the output register and pending is set.
  - If the pending flag is 1, the commit is dropped, the output register is unchanged and `cmd_overflow` is set.
- Issue:
  - When `busy` = 0 and a pending flag is set, pulse the matching valid for one cycle and clear that pending flag in the same cycle.
  - `addr_valid` has priority over `instr_valid`; they are never asserted in the same cycle.
  - After a pulse, no new issue happens until `busy` has been sampled on the following cycle. This gives a minimum of 2 cycles between pulses.
- `instruction` and `new_section_address` change only on an accepted commit, so they are stable from pending through the pulse cycle and afterwards.
- Response capture:
  - `OBI_rvalid` = 1 loads `OBI_rdata` into the RDATA register and sets `rdata_valid`.
  - If `rdata_valid` was already 1, `rdata_lost` is also set and the new data overwrites the old.
  - A host read of RDATA byte 3 clears `rdata_valid`. If `OBI_rvalid` occurs in the same cycle, the capture wins and `rdata_valid` stays 1.
- `reg_datao` is combinational from `reg_address`/`reg_bytecnt` while `reg_read` = 1, and 0 otherwise. Unmapped addresses and `bytecnt` > 3 read 0; writes to them are ignored.

## Timing
- Reset values: every output 0, all staging, output and flag registers 0.
- A reset mid-operation discards partial words and pending commands, and no pulse is emitted.
- Commit at cycle t with `busy` = 0: pending is set at t+1 and the valid pulse is seen at t+1.
- `busy` = 1: the pulse occurs on the first cycle after `busy` is sampled 0.
- `OBI_rvalid` at cycle t: RDATA and `rdata_valid` are visible at t+1.
- Every state register, including the pending flags, uses the asynchronous reset.

## Structure
- Package `bridge_host_pkg` holds:
  - register address constants (`BH_STATUS`, `BH_INSTR`, `BH_ADDR`, `BH_RDATA`, `BH_CTRL`);
  - STATUS and CTRL bit indices;
  - a typedef for the issue state: `IDLE`, `ISSUED`.
- Sub-module `bridge_word_stage`: 4-byte staging register, byte-3 commit detect and 32-bit output register. It is instantiated once for INSTR and once for ADDR.
- The top level holds decode, the pending/issue state machine, response capture and the read mux.

## Test plan
- Write INSTR bytes 0x13,0x05,0x10,0x00 with `busy` = 0 -> `instruction` = 0x00100513 and `instr_valid` high for exactly 1 cycle, one cycle after the byte-3 write.
- Commit ADDR 0x00000180 while `busy` = 1 for 5 cycles -> STATUS bit2 = 1 during the busy window, `addr_valid` pulses on the first cycle after `busy` falls, value unchanged.
- Commit ADDR then INSTR while `busy` = 1, then drop `busy` -> `addr_valid` first, `instr_valid` ≥2 cycles later, never both high together.
- Second INSTR commit while the first is still pending -> `instruction` keeps the first value and STATUS bit4 = 1; CTRL write 0x01 -> bit4 = 0.
- `OBI_rvalid` with 0xDEADBEEF -> RDATA bytes read back EF,BE,AD,DE; `rdata_valid` clears after byte 3. A second rvalid before that read sets bit5.
- Assert `rst_n` = 0 after INSTR bytes 0–2 -> after release, writing byte 3 alone commits 0xXX000000 (upper byte only), confirming the staging register was cleared.

Source files
------------

// File: rtl/bridge_host_pkg.sv
// Shared constants and types for the CW305 host register front end of the X-HEEP loader bridge.
package bridge_host_pkg;

  localparam logic [7:0] BH_STATUS = 8'h00;
  localparam logic [7:0] BH_INSTR  = 8'h01;
  localparam logic [7:0] BH_ADDR   = 8'h02;
  localparam logic [7:0] BH_RDATA  = 8'h03;
  localparam logic [7:0] BH_CTRL   = 8'h04;

  localparam int ST_BUSY        = 0;
  localparam int ST_INSTR_PEND  = 1;
  localparam int ST_ADDR_PEND   = 2;
  localparam int ST_RDATA_VALID = 3;
  localparam int ST_CMD_OVF     = 4;
  localparam int ST_RDATA_LOST  = 5;

  localparam int CTRL_CLR_OVF  = 0;
  localparam int CTRL_CLR_LOST = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ISSUED = 1'b1
  } issue_state_t;

endpackage

// File: rtl/bridge_word_stage.sv
// Byte-wise staging of a little-endian 32-bit word; a byte-3 write commits it to the output register
// when the owner says the previous command has been consumed.
module bridge_word_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  byte_sel,
  input  logic [7:0]  wr_data,
  input  logic        accept,
  output logic        commit,
  output logic [31:0] word_q
);

  logic [31:0] staging;

  assign commit = wr_en && (byte_sel == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging <= '0;
    end else if (wr_en) begin
      staging[{byte_sel, 3'b000} +: 8] <= wr_data;
    end
  end

  // Byte 3 is taken straight from the bus so the committed word is complete in the commit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (commit && accept) begin
      word_q <= {wr_data, staging[23:0]};
    end
  end

endmodule

// File: rtl/bridge_host_regs.sv
// Host register front end: decodes CW305 byte writes into instruction/section-address commands for the
// OBI bridge, captures OBI read responses, and exposes status to the host.
module bridge_host_regs
  import bridge_host_pkg::*;
#(
  parameter int pADDR_WIDTH   = 8,
  parameter int pBYTECNT_SIZE = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [pADDR_WIDTH-1:0]   reg_address,
  input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  input  logic [7:0]               reg_datai,
  output logic [7:0]               reg_datao,
  input  logic                     reg_read,
  input  logic                     reg_write,
  input  logic                     busy,
  input  logic                     OBI_rvalid,
  input  logic [31:0]              OBI_rdata,
  output logic                     instr_valid,
  output logic                     addr_valid,
  output logic [31:0]              instruction,
  output logic [31:0]              new_section_address
);

  logic         byte_ok;
  logic [1:0]   byte_sel;
  logic         hit_status, hit_instr, hit_addr, hit_rdata, hit_ctrl;
  logic         wr_instr, wr_addr, wr_ctrl;
  logic         rd_rdata_last;
  logic         instr_commit, addr_commit;
  logic         instr_pending, addr_pending;
  logic         cmd_overflow, rdata_valid, rdata_lost;
  logic [31:0]  rdata_q;
  logic [7:0]   status_byte;
  issue_state_t state_q, state_d;

  assign byte_ok  = (reg_bytecnt <= pBYTECNT_SIZE'(3));
  assign byte_sel = reg_bytecnt[1:0];

  assign hit_status = (reg_address == pADDR_WIDTH'(BH_STATUS));
  assign hit_instr  = (reg_address == pADDR_WIDTH'(BH_INSTR));
  assign hit_addr   = (reg_address == pADDR_WIDTH'(BH_ADDR));
  assign hit_rdata  = (reg_address == pADDR_WIDTH'(BH_RDATA));
  assign hit_ctrl   = (reg_address == pADDR_WIDTH'(BH_CTRL));

  assign wr_instr      = reg_write && byte_ok && hit_instr;
  assign wr_addr       = reg_write && byte_ok && hit_addr;
  assign wr_ctrl       = reg_write && byte_ok && hit_ctrl && (byte_sel == 2'd0);
  assign rd_rdata_last = reg_read && byte_ok && hit_rdata && (byte_sel == 2'd3);

  bridge_word_stage u_instr_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_instr),
    .byte_sel (byte_sel),
    .wr_data  (reg_datai),
    .accept   (!instr_pending),
    .commit   (instr_commit),
    .word_q   (instruction)
  );

  bridge_word_stage u_addr_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_addr),
    .byte_sel (byte_sel),
    .wr_data  (reg_datai),
    .accept   (!addr_pending),
    .commit   (addr_commit),
    .word_q   (new_section_address)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid || addr_valid) state_d = ISSUED;
      ISSUED:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ISSUED blocks one cycle so the bridge's busy response to a pulse is seen before the next issue.
  always_comb begin
    addr_valid  = 1'b0;
    instr_valid = 1'b0;
    if (state_q == IDLE && !busy) begin
      addr_valid  = addr_pending;
      instr_valid = instr_pending && !addr_pending;
    end
  end

  // A commit can only be accepted while not pending, so it never collides with the clearing pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_pending <= 1'b0;
      addr_pending  <= 1'b0;
      cmd_overflow  <= 1'b0;
    end else begin
      if (instr_commit && !instr_pending) begin
        instr_pending <= 1'b1;
      end else if (instr_valid) begin
        instr_pending <= 1'b0;
      end
      if (addr_commit && !addr_pending) begin
        addr_pending <= 1'b1;
      end else if (addr_valid) begin
        addr_pending <= 1'b0;
      end
      if ((instr_commit && instr_pending) || (addr_commit && addr_pending)) begin
        cmd_overflow <= 1'b1;
      end else if (wr_ctrl && reg_datai[CTRL_CLR_OVF]) begin
        cmd_overflow <= 1'b0;
      end
    end
  end

  // A fresh capture beats both the host's read-clear and a CTRL clear of the lost flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q     <= '0;
      rdata_valid <= 1'b0;
      rdata_lost  <= 1'b0;
    end else begin
      if (OBI_rvalid) begin
        rdata_q <= OBI_rdata;
      end
      if (OBI_rvalid) begin
        rdata_valid <= 1'b1;
      end else if (rd_rdata_last) begin
        rdata_valid <= 1'b0;
      end
      if (OBI_rvalid && rdata_valid) begin
        rdata_lost <= 1'b1;
      end else if (wr_ctrl && reg_datai[CTRL_CLR_LOST]) begin
        rdata_lost <= 1'b0;
      end
    end
  end

  always_comb begin
    status_byte                 = '0;
    status_byte[ST_BUSY]        = busy;
    status_byte[ST_INSTR_PEND]  = instr_pending;
    status_byte[ST_ADDR_PEND]   = addr_pending;
    status_byte[ST_RDATA_VALID] = rdata_valid;
    status_byte[ST_CMD_OVF]     = cmd_overflow;
    status_byte[ST_RDATA_LOST]  = rdata_lost;
  end

  always_comb begin
    reg_datao = '0;
    if (reg_read && byte_ok) begin
      if (hit_status && byte_sel == 2'd0) begin
        reg_datao = status_byte;
      end else if (hit_rdata) begin
        reg_datao = rdata_q[{byte_sel, 3'b000} +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bridge_host_regs.sv
// Scoreboard bench for bridge_host_regs: commands are queued at commit and matched against valid pulses.
module tb_bridge_host_regs;

  typedef struct {
    bit          is_addr;
    logic [31:0] value;
  } cmd_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  reg_address;
  logic [6:0]  reg_bytecnt;
  logic [7:0]  reg_datai;
  logic [7:0]  reg_datao;
  logic        reg_read;
  logic        reg_write;
  logic        busy;
  logic        OBI_rvalid;
  logic [31:0] OBI_rdata;
  logic        instr_valid;
  logic        addr_valid;
  logic [31:0] instruction;
  logic [31:0] new_section_address;

  int   errors = 0;
  int   checks = 0;
  cmd_t cmd_q[$];
  logic [7:0] rd_q[$];

  bridge_host_regs #(.pADDR_WIDTH(8), .pBYTECNT_SIZE(7)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .reg_address         (reg_address),
    .reg_bytecnt         (reg_bytecnt),
    .reg_datai           (reg_datai),
    .reg_datao           (reg_datao),
    .reg_read            (reg_read),
    .reg_write           (reg_write),
    .busy                (busy),
    .OBI_rvalid          (OBI_rvalid),
    .OBI_rdata           (OBI_rdata),
    .instr_valid         (instr_valid),
    .addr_valid          (addr_valid),
    .instruction         (instruction),
    .new_section_address (new_section_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every pulse must match the oldest outstanding commit, in kind and value.
  always @(negedge clk) begin
    if (rst_n && (instr_valid || addr_valid)) begin
      cmd_t exp;
      checks++;
      if (instr_valid && addr_valid) begin
        errors++;
        $display("[TB] FAIL both_valid: instr_valid=%b addr_valid=%b, required never both", instr_valid, addr_valid);
      end else if (cmd_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_pulse: instr_valid=%b addr_valid=%b, required no pulse", instr_valid, addr_valid);
      end else begin
        exp = cmd_q.pop_front();
        if (addr_valid !== exp.is_addr) begin
          errors++;
          $display("[TB] FAIL pulse_kind: addr_valid=%b, required %b", addr_valid, exp.is_addr);
        end else if (exp.is_addr && new_section_address !== exp.value) begin
          errors++;
          $display("[TB] FAIL pulse_addr: got %h, required %h", new_section_address, exp.value);
        end else if (!exp.is_addr && instruction !== exp.value) begin
          errors++;
          $display("[TB] FAIL pulse_instr: got %h, required %h", instruction, exp.value);
        end
      end
    end
  end

  task automatic host_write(input logic [7:0] a, input logic [6:0] c, input logic [7:0] d);
    reg_address = a;
    reg_bytecnt = c;
    reg_datai   = d;
    reg_write   = 1'b1;
    @(posedge clk); #1;
    reg_write   = 1'b0;
  endtask

  task automatic host_write_word(input logic [7:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) host_write(a, 7'(i), w[8*i +: 8]);
  endtask

  task automatic host_read(input logic [7:0] a, input logic [6:0] c, output logic [7:0] d);
    reg_address = a;
    reg_bytecnt = c;
    reg_read    = 1'b1;
    @(negedge clk);
    d = reg_datao;
    @(posedge clk); #1;
    reg_read    = 1'b0;
  endtask

  task automatic check_status(input string name, input logic [7:0] expv);
    logic [7:0] d;
    host_read(8'h00, 7'd0, d);
    checks++;
    if (d !== expv) begin
      errors++;
      $display("[TB] FAIL %s: status=%h, required %h", name, d, expv);
    end
  endtask

  task automatic pulse_rvalid(input logic [31:0] data);
    OBI_rvalid = 1'b1;
    OBI_rdata  = data;
    @(posedge clk); #1;
    OBI_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || addr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valids: instr=%b addr=%b, required 0 0", instr_valid, addr_valid);
    end
    checks++;
    if (instruction !== 32'h0 || new_section_address !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_words: instr=%h addr=%h, required 0 0", instruction, new_section_address);
    end
    checks++;
    if (reg_datao !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_datao: got %h, required 00", reg_datao);
    end
    check_status("reset_status", 8'h00);
    host_read(8'h03, 7'd0, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got %h, required 00", d);
    end
  endtask

  task automatic test_instr_commit;
    cmd_q.push_back('{1'b0, 32'h00100513});
    host_write_word(8'h01, 32'h00100513);
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instruction !== 32'h00100513) begin
      errors++;
      $display("[TB] FAIL instr_pulse: valid=%b instr=%h, required 1 00100513", instr_valid, instruction);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL instr_one_cycle: valid=%b, required 0", instr_valid);
    end
  endtask

  task automatic test_busy_hold;
    busy = 1'b1;
    cmd_q.push_back('{1'b1, 32'h00000180});
    host_write_word(8'h02, 32'h00000180);
    reg_address = 8'h00;
    reg_bytecnt = 7'd0;
    reg_read    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (reg_datao !== 8'h05 || addr_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL busy_window: status=%h addr_valid=%b, required 05 0", reg_datao, addr_valid);
      end
    end
    @(posedge clk); #1;
    busy = 1'b0;
    @(negedge clk);
    checks++;
    if (addr_valid !== 1'b1 || new_section_address !== 32'h00000180) begin
      errors++;
      $display("[TB] FAIL busy_release: valid=%b addr=%h, required 1 00000180", addr_valid, new_section_address);
    end
    @(negedge clk);
    checks++;
    if (addr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_one_cycle: valid=%b, required 0", addr_valid);
    end
    reg_read = 1'b0;
  endtask

  task automatic test_priority;
    int a_cyc = -1;
    int i_cyc = -1;
    busy = 1'b1;
    cmd_q.push_back('{1'b1, 32'h00000200});
    host_write_word(8'h02, 32'h00000200);
    cmd_q.push_back('{1'b0, 32'h00000093});
    host_write_word(8'h01, 32'h00000093);
    busy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (addr_valid && a_cyc < 0) a_cyc = c;
      if (instr_valid && i_cyc < 0) i_cyc = c;
    end
    checks++;
    if (a_cyc != 0) begin
      errors++;
      $display("[TB] FAIL prio_addr_first: addr cycle=%0d, required 0", a_cyc);
    end
    checks++;
    if (i_cyc < 0 || i_cyc < a_cyc + 2) begin
      errors++;
      $display("[TB] FAIL prio_gap: instr cycle=%0d addr cycle=%0d, required gap >= 2", i_cyc, a_cyc);
    end
  endtask

  task automatic test_overflow;
    busy = 1'b1;
    cmd_q.push_back('{1'b0, 32'h11111111});
    host_write_word(8'h01, 32'h11111111);
    host_write_word(8'h01, 32'h22222222);
    checks++;
    if (instruction !== 32'h11111111) begin
      errors++;
      $display("[TB] FAIL ovf_keep: instr=%h, required 11111111", instruction);
    end
    check_status("ovf_set", 8'h13);
    host_write(8'h04, 7'd0, 8'h01);
    check_status("ovf_clear", 8'h03);
    busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (instruction !== 32'h11111111) begin
      errors++;
      $display("[TB] FAIL ovf_after_issue: instr=%h, required 11111111", instruction);
    end
    check_status("ovf_idle", 8'h00);
  endtask

  task automatic test_rdata;
    logic [7:0] d;
    logic [7:0] expb;
    pulse_rvalid(32'hDEADBEEF);
    rd_q.push_back(8'hEF);
    rd_q.push_back(8'hBE);
    rd_q.push_back(8'hAD);
    rd_q.push_back(8'hDE);
    check_status("rdata_valid_set", 8'h08);
    for (int i = 0; i < 4; i++) begin
      host_read(8'h03, 7'(i), d);
      expb = rd_q.pop_front();
      checks++;
      if (d !== expb) begin
        errors++;
        $display("[TB] FAIL rdata_byte%0d: got %h, required %h", i, d, expb);
      end
    end
    check_status("rdata_valid_clear", 8'h00);
    pulse_rvalid(32'h12345678);
    pulse_rvalid(32'hCAFEF00D);
    check_status("rdata_lost_set", 8'h28);
    host_read(8'h03, 7'd0, d);
    checks++;
    if (d !== 8'h0D) begin
      errors++;
      $display("[TB] FAIL rdata_overwrite: got %h, required 0D", d);
    end
    reg_address = 8'h03;
    reg_bytecnt = 7'd3;
    reg_read    = 1'b1;
    OBI_rvalid  = 1'b1;
    OBI_rdata   = 32'h0BADC0DE;
    @(posedge clk); #1;
    reg_read    = 1'b0;
    OBI_rvalid  = 1'b0;
    check_status("rdata_capture_wins", 8'h28);
    host_write(8'h04, 7'd0, 8'h02);
    check_status("rdata_lost_clear", 8'h08);
    host_read(8'h03, 7'd3, d);
    checks++;
    if (d !== 8'h0B) begin
      errors++;
      $display("[TB] FAIL rdata_new_byte3: got %h, required 0B", d);
    end
    check_status("rdata_drained", 8'h00);
  endtask

  task automatic test_unmapped;
    logic [7:0] d;
    busy = 1'b1;
    host_read(8'h07, 7'd0, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("[TB] FAIL unmapped_read: got %h, required 00", d);
    end
    host_read(8'h00, 7'd4, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("[TB] FAIL bytecnt_gt3_read: got %h, required 00", d);
    end
    reg_address = 8'h00;
    reg_bytecnt = 7'd0;
    @(negedge clk);
    checks++;
    if (reg_datao !== 8'h00) begin
      errors++;
      $display("[TB] FAIL no_read_strobe: got %h, required 00", reg_datao);
    end
    host_write(8'h01, 7'd7, 8'hFF);
    check_status("bytecnt_gt3_write", 8'h01);
    busy = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    busy = 1'b1;
    host_write_word(8'h02, 32'h0000ABCD);
    host_write(8'h01, 7'd0, 8'hAA);
    host_write(8'h01, 7'd1, 8'hBB);
    host_write(8'h01, 7'd2, 8'hCC);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    busy  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (new_section_address !== 32'h0 || instruction !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_words: addr=%h instr=%h, required 0 0", new_section_address, instruction);
    end
    check_status("mid_reset_status", 8'h00);
    cmd_q.push_back('{1'b0, 32'h5A000000});
    host_write(8'h01, 7'd3, 8'h5A);
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instruction !== 32'h5A000000) begin
      errors++;
      $display("[TB] FAIL mid_reset_commit: valid=%b instr=%h, required 1 5A000000", instr_valid, instruction);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    reg_address = '0;
    reg_bytecnt = '0;
    reg_datai   = '0;
    reg_read    = 1'b0;
    reg_write   = 1'b0;
    busy        = 1'b0;
    OBI_rvalid  = 1'b0;
    OBI_rdata   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    test_reset();
    test_instr_commit();
    test_busy_hold();
    test_priority();
    test_overflow();
    test_rdata();
    test_unmapped();
    test_reset_mid();

    checks++;
    if (cmd_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_pulses: %0d outstanding, required 0", cmd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
